// File: rtl/jtag_debug_pkg.sv
// Shared defaults, IR codes and command entry layout for the debug-slave command path.
package jtag_debug_pkg;
  localparam int DEF_DATA_W      = 38;
  localparam int DEF_IR_W        = 2;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_FIFO_DEPTH  = 4;
  localparam int DEF_ACT_BIT     = 35;

  localparam logic [DEF_IR_W-1:0] IR_OCIMEM    = 2'd0;
  localparam logic [DEF_IR_W-1:0] IR_TRACEMEM  = 2'd1;
  localparam logic [DEF_IR_W-1:0] IR_BREAK     = 2'd2;
  localparam logic [DEF_IR_W-1:0] IR_TRACECTRL = 2'd3;

  typedef struct packed {
    logic [DEF_IR_W-1:0]   ir;
    logic [DEF_DATA_W-1:0] data;
  } cmd_entry_t;
endpackage

// File: rtl/dbg_sync_edge.sv
// Level synchroniser with arm flop: reports a rise only after a genuine low has been seen
// since reset, so a strobe already high at reset release is ignored.
module dbg_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_rise
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic [SYNC_STAGES-1:0] r_fill;
  logic                   r_prev;
  logic                   r_arm;

  // r_fill marks when the last stage holds a real post-reset sample rather than the reset zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '0;
      r_fill <= '0;
      r_prev <= 1'b0;
      r_arm  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_fill <= {r_fill[SYNC_STAGES-2:0], 1'b1};
      r_prev <= r_sync[SYNC_STAGES-1];
      if (r_fill[SYNC_STAGES-1] && !r_sync[SYNC_STAGES-1]) r_arm <= 1'b1;
    end
  end

  assign o_rise = r_arm && r_sync[SYNC_STAGES-1] && !r_prev;
endmodule

// File: rtl/jtag_debug_cmd_sync.sv
// System-clock side of the debug slave: syncs update strobes, buffers DR captures,
// and hands commands out over valid/ready with per-IR action strobes.
module jtag_debug_cmd_sync
  import jtag_debug_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int IR_W        = DEF_IR_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int ACT_BIT     = DEF_ACT_BIT
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            vs_udr,
  input  logic                            vs_uir,
  input  logic [IR_W-1:0]                 ir_in,
  input  logic [DATA_W-1:0]               sr,
  output logic                            cmd_valid,
  input  logic                            cmd_ready,
  output logic [DATA_W-1:0]               jdo,
  output logic [IR_W-1:0]                 cmd_ir,
  output logic [(1<<IR_W)-1:0]            take_action,
  output logic [(1<<IR_W)-1:0]            take_no_action,
  output logic                            ir_update,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            overflow,
  input  logic                            clear_overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = IR_W + DATA_W;
  localparam logic [AW:0] ONE = 1;

  logic w_udr_rise, w_uir_rise;

  dbg_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_udr_sync (
    .clk(clk), .reset(reset), .i_async(vs_udr), .o_rise(w_udr_rise)
  );
  dbg_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_uir_sync (
    .clk(clk), .reset(reset), .i_async(vs_uir), .o_rise(w_uir_rise)
  );

  logic [EW-1:0]     r_mem [FIFO_DEPTH];
  logic [AW:0]       r_wptr, r_rptr;
  logic [EW-1:0]     r_head;
  logic [(1<<IR_W)-1:0] r_act, r_noact;
  logic              r_ir_update, r_ovf;

  logic [AW:0]       w_level, w_rptr_nx;
  logic              w_empty, w_full, w_pop, w_push, w_drop;
  logic [EW-1:0]     w_din;
  logic [IR_W-1:0]   w_head_ir;

  assign w_din     = {ir_in, sr};
  assign w_level   = r_wptr - r_rptr;
  assign w_rptr_nx = r_rptr + ONE;
  assign w_empty   = (r_wptr == r_rptr);
  assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop     = !w_empty && cmd_ready;
  assign w_push    = w_udr_rise && (!w_full || w_pop);
  assign w_drop    = w_udr_rise && w_full && !w_pop;
  assign w_head_ir = r_head[EW-1:DATA_W];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= w_din;
  end

  // r_head is a registered copy of the head entry so the last popped command stays visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_head      <= '0;
      r_act       <= '0;
      r_noact     <= '0;
      r_ir_update <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_act       <= '0;
      r_noact     <= '0;
      r_ir_update <= w_uir_rise;
      if (w_push) r_wptr <= r_wptr + ONE;
      if (w_pop)  r_rptr <= w_rptr_nx;
      if (w_pop && (w_level > ONE))       r_head <= r_mem[w_rptr_nx[AW-1:0]];
      else if (w_push && (w_empty || w_pop)) r_head <= w_din;
      if (w_pop) begin
        if (r_head[ACT_BIT]) r_act[w_head_ir]   <= 1'b1;
        else                 r_noact[w_head_ir] <= 1'b1;
      end
      if (w_drop)              r_ovf <= 1'b1;
      else if (clear_overflow) r_ovf <= 1'b0;
    end
  end

  assign cmd_valid      = !w_empty;
  assign jdo            = r_head[DATA_W-1:0];
  assign cmd_ir         = w_head_ir;
  assign take_action    = r_act;
  assign take_no_action = r_noact;
  assign ir_update      = r_ir_update;
  assign fifo_level     = w_level;
  assign overflow       = r_ovf;
endmodule

// File: tb/tb_jtag_debug_cmd_sync.sv
// Directed bench for jtag_debug_cmd_sync at default parameters.
module tb_jtag_debug_cmd_sync;
  logic        clk = 1'b0;
  logic        reset;
  logic        vs_udr, vs_uir;
  logic [1:0]  ir_in;
  logic [37:0] sr;
  logic        cmd_valid, cmd_ready;
  logic [37:0] jdo;
  logic [1:0]  cmd_ir;
  logic [3:0]  take_action, take_no_action;
  logic        ir_update;
  logic [2:0]  fifo_level;
  logic        overflow, clear_overflow;

  int errors = 0;
  int checks = 0;

  jtag_debug_cmd_sync dut (
    .clk(clk), .reset(reset), .vs_udr(vs_udr), .vs_uir(vs_uir),
    .ir_in(ir_in), .sr(sr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .jdo(jdo), .cmd_ir(cmd_ir), .take_action(take_action),
    .take_no_action(take_no_action), .ir_update(ir_update),
    .fifo_level(fifo_level), .overflow(overflow), .clear_overflow(clear_overflow)
  );

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [37:0] mk_sr(input logic act, input logic [7:0] b);
    logic [37:0] v;
    v = '0;
    v[35] = act;
    v[7:0] = b;
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; vs_udr = 1'b0; vs_uir = 1'b0; ir_in = '0; sr = '0;
    cmd_ready = 1'b0; clear_overflow = 1'b0;
    step(3);
    reset = 1'b0;
    step(5);
  endtask

  task automatic pulse_udr(input logic [1:0] ir, input logic act, input logic [7:0] b);
    ir_in = ir; sr = mk_sr(act, b); vs_udr = 1'b1;
    step(4);
    vs_udr = 1'b0;
    step(4);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; vs_udr = 1'b0; vs_uir = 1'b0; ir_in = '0; sr = '0;
    cmd_ready = 1'b0; clear_overflow = 1'b0;
    step(3);
    checks++;
    if ({cmd_valid, jdo, cmd_ir, take_action, take_no_action, ir_update, fifo_level, overflow} !== '0) begin
      errors++;
      $display("FAIL reset_state: got valid=%b jdo=%h ir=%h act=%b noact=%b iru=%b lvl=%0d ovf=%b expected all zero",
               cmd_valid, jdo, cmd_ir, take_action, take_no_action, ir_update, fifo_level, overflow);
    end
    reset = 1'b0;
    step(5);
  endtask

  task automatic test_basic();
    cmd_ready = 1'b1; ir_in = 2'd2; sr = mk_sr(1'b1, 8'hA5); vs_udr = 1'b1;
    step(); checks++;
    if (cmd_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_e0: got %b expected 0", cmd_valid); end
    step(); checks++;
    if (cmd_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_e1: got %b expected 0", cmd_valid); end
    step(); checks++;
    if (cmd_valid !== 1'b1 || jdo[7:0] !== 8'hA5 || cmd_ir !== 2'd2 || fifo_level !== 3'd1) begin
      errors++;
      $display("FAIL basic_head_e2: got valid=%b jdo=%h ir=%0d lvl=%0d expected 1 A5 2 1", cmd_valid, jdo[7:0], cmd_ir, fifo_level);
    end
    step(); checks++;
    if (take_action !== 4'b0100 || take_no_action !== 4'b0000 || cmd_valid !== 1'b0 ||
        fifo_level !== 3'd0 || jdo[7:0] !== 8'hA5) begin
      errors++;
      $display("FAIL basic_strobe: got act=%b noact=%b valid=%b lvl=%0d jdo=%h expected 0100 0000 0 0 A5",
               take_action, take_no_action, cmd_valid, fifo_level, jdo[7:0]);
    end
    step(); checks++;
    if (take_action !== 4'b0000) begin errors++; $display("FAIL basic_strobe_len: got %b expected 0000", take_action); end
    vs_udr = 1'b0;
    step(4);
  endtask

  task automatic test_held_high();
    int seen;
    @(negedge clk);
    reset = 1'b1; cmd_ready = 1'b1; ir_in = 2'd1; sr = mk_sr(1'b0, 8'h3C); vs_udr = 1'b1;
    step(3);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin step(); if (cmd_valid) seen++; end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL held_high_no_cmd: got %0d valid cycles expected 0", seen); end
    vs_udr = 1'b0;
    step(4);
    vs_udr = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin step(); if (cmd_valid) seen++; end
    checks++;
    if (seen !== 1) begin errors++; $display("FAIL toggle_one_cmd: got %0d valid cycles expected 1", seen); end
    vs_udr = 1'b0;
    step(4);
  endtask

  task automatic test_overflow();
    do_reset();
    for (int k = 0; k < 5; k++) pulse_udr(2'(k % 4), k[0], 8'h10 + 8'(k));
    checks++;
    if (fifo_level !== 3'd4 || overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_fill: got lvl=%0d ovf=%b expected 4 1", fifo_level, overflow);
    end
    cmd_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (cmd_valid !== 1'b1 || cmd_ir !== 2'(k) || jdo[7:0] !== 8'h10 + 8'(k)) begin
        errors++; $display("FAIL ovf_order_%0d: got valid=%b ir=%0d jdo=%h expected 1 %0d %h",
                           k, cmd_valid, cmd_ir, jdo[7:0], k, 8'h10 + 8'(k));
      end
      step(); checks++;
      if (take_action !== (k[0] ? 4'(1 << k) : 4'b0) || take_no_action !== (k[0] ? 4'b0 : 4'(1 << k))) begin
        errors++; $display("FAIL ovf_strobe_%0d: got act=%b noact=%b", k, take_action, take_no_action);
      end
    end
    checks++;
    if (cmd_valid !== 1'b0 || fifo_level !== 3'd0 || jdo[7:0] !== 8'h13 || cmd_ir !== 2'd3) begin
      errors++; $display("FAIL ovf_drained: got valid=%b lvl=%0d jdo=%h ir=%0d expected 0 0 13 3",
                         cmd_valid, fifo_level, jdo[7:0], cmd_ir);
    end
    step();
  endtask

  task automatic test_full_pop();
    logic [7:0] exp_b [4];
    do_reset();
    for (int k = 0; k < 4; k++) pulse_udr(2'(k), 1'b0, 8'h20 + 8'(k));
    ir_in = 2'd1; sr = mk_sr(1'b1, 8'h55); vs_udr = 1'b1;
    step(2);
    cmd_ready = 1'b1;
    step(); checks++;
    if (fifo_level !== 3'd4 || overflow !== 1'b0) begin
      errors++; $display("FAIL full_pop_same_cycle: got lvl=%0d ovf=%b expected 4 0", fifo_level, overflow);
    end
    cmd_ready = 1'b0;
    step(); vs_udr = 1'b0; step(3);
    exp_b[0] = 8'h21; exp_b[1] = 8'h22; exp_b[2] = 8'h23; exp_b[3] = 8'h55;
    cmd_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (jdo[7:0] !== exp_b[k]) begin
        errors++; $display("FAIL full_pop_order_%0d: got %h expected %h", k, jdo[7:0], exp_b[k]);
      end
      step();
    end
    checks++;
    if (take_action !== 4'b0010) begin errors++; $display("FAIL full_pop_last_strobe: got %b expected 0010", take_action); end
    cmd_ready = 1'b0;
  endtask

  task automatic test_ir_update();
    do_reset();
    vs_uir = 1'b1;
    step(); checks++;
    if (ir_update !== 1'b0) begin errors++; $display("FAIL iru_e0: got %b expected 0", ir_update); end
    step(); checks++;
    if (ir_update !== 1'b0) begin errors++; $display("FAIL iru_e1: got %b expected 0", ir_update); end
    step(); checks++;
    if (ir_update !== 1'b1) begin errors++; $display("FAIL iru_e2: got %b expected 1", ir_update); end
    step(); checks++;
    if (ir_update !== 1'b0 || fifo_level !== 3'd0 || cmd_valid !== 1'b0) begin
      errors++; $display("FAIL iru_e3: got iru=%b lvl=%0d valid=%b expected 0 0 0", ir_update, fifo_level, cmd_valid);
    end
    vs_uir = 1'b0;
    step(3);
  endtask

  task automatic test_clear_vs_drop();
    do_reset();
    for (int k = 0; k < 4; k++) pulse_udr(2'(k), 1'b1, 8'h40 + 8'(k));
    checks++;
    if (overflow !== 1'b0 || fifo_level !== 3'd4) begin
      errors++; $display("FAIL clr_pre: got ovf=%b lvl=%0d expected 0 4", overflow, fifo_level);
    end
    ir_in = 2'd3; sr = mk_sr(1'b0, 8'h99); vs_udr = 1'b1;
    step(2);
    clear_overflow = 1'b1;
    step(); checks++;
    if (overflow !== 1'b1 || fifo_level !== 3'd4) begin
      errors++; $display("FAIL clr_drop_wins: got ovf=%b lvl=%0d expected 1 4", overflow, fifo_level);
    end
    step(); checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL clr_alone: got %b expected 0", overflow); end
    clear_overflow = 1'b0;
    vs_udr = 1'b0;
    step(3);
    do_reset();
    checks++;
    if (cmd_valid !== 1'b0 || fifo_level !== 3'd0 || jdo !== '0 || overflow !== 1'b0) begin
      errors++; $display("FAIL reset_discard: got valid=%b lvl=%0d jdo=%h ovf=%b expected 0 0 0 0",
                         cmd_valid, fifo_level, jdo, overflow);
    end
  endtask

  initial begin
    reset = 1'b1; vs_udr = 1'b0; vs_uir = 1'b0; ir_in = '0; sr = '0;
    cmd_ready = 1'b0; clear_overflow = 1'b0;
    test_reset();
    test_basic();
    test_held_high();
    test_overflow();
    test_full_pop();
    test_ir_update();
    test_clear_vs_drop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
